mcu_rst_sequencer: RTL and testbench
====================================

MCU_RST_SEQUENCER -- requirements
Module: mcu_rst_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, minimum reset-assert time in clocks, legal range >= 2.
REQ-002 Parameter STAGE_GAP, default 4, clocks between successive domain releases, legal range >= 1.
REQ-003 sys_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 sys_rst  in  1  reset, synchronous and active-high; driven by the already-synchronised power-on reset.
REQ-005 cpu_pad_soft_rst  in  2  bit0 is the core soft-reset request, bit1 is the system soft-reset request; level, sys_clk-synchronous.
REQ-006 wdt_rst_req  in  1  watchdog system reset request; level.
REQ-007 had_dbg_rst_req  in  1  debugger core reset request; level.
REQ-008 rst_cause_clr  in  1  single-cycle clear of rst_cause.
REQ-009 periph_rst_b  out  1  peripheral/bus reset, active-low.
REQ-010 pad_had_rst_b  out  1  HAD debug reset, active-low.
REQ-011 pad_cpu_rst_b  out  1  CPU core reset, active-low.
REQ-012 rst_cause  out  5  sticky cause bits: {por, dbg, wdt, sys_soft, cpu_soft}.
REQ-013 seq_busy  out  1  high whenever the state is not RUN.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have states RUN, SYS_HOLD, REL_PERIPH, REL_HAD and CORE_HOLD, plus an internal stage counter.
REQ-016 A system-class request SHALL be cpu_pad_soft_rst[1] | wdt_rst_req.
REQ-017 A core-class request SHALL be cpu_pad_soft_rst[0] | had_dbg_rst_req.
REQ-018 In RUN, a system-class request SHALL move the FSM to SYS_HOLD.
- All three reset outputs go low on the next edge.
- The counter is cleared.
REQ-019 In RUN, a core-class request without a system-class request SHALL move the FSM to CORE_HOLD.
- Only pad_cpu_rst_b goes low on the next edge.
- The counter is cleared.
REQ-020 Simultaneous system-class and core-class requests SHALL be handled as system-class; the cause bits of every request active in that cycle SHALL be set.
REQ-021 SYS_HOLD SHALL exit to REL_PERIPH only when the counter has reached HOLD_CYCLES-1 and no system-class request is active.
- periph_rst_b rises on the exit edge.
- A held request extends the assert time indefinitely.
REQ-022 REL_PERIPH SHALL last STAGE_GAP cycles and then enter REL_HAD; pad_had_rst_b rises on the transition edge.
REQ-023 REL_HAD SHALL last STAGE_GAP cycles and then enter RUN; pad_cpu_rst_b rises on the transition edge.
REQ-024 The release order SHALL therefore be: periph_rst_b, then pad_had_rst_b, then pad_cpu_rst_b, each STAGE_GAP clocks apart; no output SHALL rise out of this order.
REQ-025 A system-class request in CORE_HOLD, REL_PERIPH or REL_HAD SHALL re-enter SYS_HOLD.
- All outputs go low on the next edge.
- The counter is cleared.
REQ-026 CORE_HOLD SHALL exit to RUN only when the counter has reached HOLD_CYCLES-1 and no core-class request is active.
- pad_cpu_rst_b rises on the exit edge.
- pad_had_rst_b and periph_rst_b stay high throughout.
REQ-027 Core-class requests outside RUN SHALL only set their cause bit and SHALL NOT alter sequencing.
REQ-028 rst_cause bits SHALL be set on the edge following an accepted request; the set SHALL win over a simultaneous rst_cause_clr.
REQ-029 rst_cause_clr SHALL clear all bits, including por, on the next edge.
REQ-030 The counter SHALL saturate and never wrap; its width SHALL be clog2(max(HOLD_CYCLES, STAGE_GAP)) + 1.

Reset
REQ-031 While sys_rst=1, on every edge:
- state is SYS_HOLD and the counter is 0;
- periph_rst_b, pad_had_rst_b and pad_cpu_rst_b are 0;
- seq_busy is 1;
- rst_cause is 5'b10000.
REQ-032 After sys_rst deasserts, the first edge with sys_rst=0 SHALL be counted as cycle 0.
- periph_rst_b rises at edge HOLD_CYCLES.
- pad_had_rst_b rises at edge HOLD_CYCLES+STAGE_GAP.
- pad_cpu_rst_b rises at edge HOLD_CYCLES+2*STAGE_GAP, and the FSM is then in RUN.
REQ-033 sys_rst asserted mid-sequence SHALL abort the sequence immediately to the REQ-031 state.

Structure
REQ-034 Package mcu_rst_pkg SHALL hold:
- the FSM state enum;
- the rst_cause bit-index constants;
- the POR cause value 5'b10000.
REQ-035 One sub-module, mcu_rst_stage_timer, SHALL provide the clearable, saturating counter with a terminal-count flag; the FSM and output registers stay in the top.

Verification (defaults HOLD_CYCLES=16, STAGE_GAP=4)
REQ-036 sys_rst high for 3 cycles, then low -> periph_rst_b rises at edge 16, pad_had_rst_b at 20, pad_cpu_rst_b at 24; rst_cause=5'b10000; seq_busy falls at edge 24.
REQ-037 In RUN, cpu_pad_soft_rst=2'b01 for 1 cycle -> only pad_cpu_rst_b low for 16 cycles; rst_cause[0] set; other resets stay high.
REQ-038 In RUN, wdt_rst_req held high for 40 cycles -> all resets stay low until 16 cycles have elapsed and the request has dropped, then staggered release 4 cycles apart; rst_cause[2] set.
REQ-039 cpu_pad_soft_rst[0] and wdt_rst_req rise in the same cycle -> full system sequence; rst_cause[2] and rst_cause[0] both set.
REQ-040 cpu_pad_soft_rst[1] pulse during REL_PERIPH -> all outputs low next edge; full 16+4+4 sequence restarts; no out-of-order rise.
REQ-041 rst_cause_clr coincident with had_dbg_rst_req in RUN -> rst_cause=5'b01000 afterwards.

Source files
------------

// File: rtl/mcu_rst_pkg.sv
// mcu_rst_pkg: shared state encoding and reset-cause constants for the reset sequencer
package mcu_rst_pkg;
  typedef enum logic [2:0] {RUN, SYS_HOLD, REL_PERIPH, REL_HAD, CORE_HOLD} rst_state_e;
  localparam int CAUSE_CPU_SOFT = 0;
  localparam int CAUSE_SYS_SOFT = 1;
  localparam int CAUSE_WDT      = 2;
  localparam int CAUSE_DBG      = 3;
  localparam int CAUSE_POR      = 4;
  localparam logic [4:0] POR_CAUSE = 5'b10000;
endpackage

// File: rtl/mcu_rst_stage_timer.sv
// mcu_rst_stage_timer: clearable saturating stage counter with terminal-count flag
module mcu_rst_stage_timer #(
  parameter int W = 5
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge sys_clk)
    if (sys_rst || clr) cnt <= '0;
    else if (cnt != '1) cnt <= cnt + W'(1);
  assign tc = cnt >= limit;
endmodule

// File: rtl/mcu_rst_sequencer.sv
// mcu_rst_sequencer: staged release of peripheral, debug and core resets with sticky cause log
module mcu_rst_sequencer
  import mcu_rst_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] cpu_pad_soft_rst,
  input  logic       wdt_rst_req,
  input  logic       had_dbg_rst_req,
  input  logic       rst_cause_clr,
  output logic       periph_rst_b,
  output logic       pad_had_rst_b,
  output logic       pad_cpu_rst_b,
  output logic [4:0] rst_cause,
  output logic       seq_busy
);
  localparam int CW = $clog2(HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP) + 1;
  rst_state_e state, state_nx;
  logic sys_req, core_req, tc, rst_q, clr;
  logic [CW-1:0] limit;
  logic [4:0] cause_set;
  assign sys_req  = cpu_pad_soft_rst[1] | wdt_rst_req;
  assign core_req = cpu_pad_soft_rst[0] | had_dbg_rst_req;
  assign limit = (state == REL_PERIPH || state == REL_HAD) ? CW'(STAGE_GAP - 1) : CW'(HOLD_CYCLES - 1);
  // the first edge after power-on reset acts as the entry edge, so hold time matches a soft entry
  assign clr = rst_q | (state_nx != state);
  assign cause_set = {1'b0, had_dbg_rst_req, wdt_rst_req, cpu_pad_soft_rst[1], cpu_pad_soft_rst[0]};
  mcu_rst_stage_timer #(.W(CW)) u_timer (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .clr(clr),
    .limit(limit),
    .tc(tc)
  );
  always_comb begin
    state_nx = state;
    case (state)
      RUN:        state_nx = sys_req ? SYS_HOLD : core_req ? CORE_HOLD : RUN;
      SYS_HOLD:   state_nx = (tc && !sys_req) ? REL_PERIPH : SYS_HOLD;
      REL_PERIPH: state_nx = sys_req ? SYS_HOLD : tc ? REL_HAD : REL_PERIPH;
      REL_HAD:    state_nx = sys_req ? SYS_HOLD : tc ? RUN : REL_HAD;
      CORE_HOLD:  state_nx = sys_req ? SYS_HOLD : (tc && !core_req) ? RUN : CORE_HOLD;
      default:    state_nx = SYS_HOLD;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    rst_q <= sys_rst;
    if (sys_rst) begin
      state         <= SYS_HOLD;
      periph_rst_b  <= 1'b0;
      pad_had_rst_b <= 1'b0;
      pad_cpu_rst_b <= 1'b0;
      seq_busy      <= 1'b1;
      rst_cause     <= POR_CAUSE;
    end else begin
      state         <= state_nx;
      periph_rst_b  <= state_nx != SYS_HOLD;
      pad_had_rst_b <= state_nx inside {RUN, CORE_HOLD, REL_HAD};
      pad_cpu_rst_b <= state_nx == RUN;
      seq_busy      <= state_nx != RUN;
      rst_cause     <= (rst_cause_clr ? 5'b0 : rst_cause) | cause_set;
    end
  end
endmodule

// File: tb/tb_mcu_rst_sequencer.sv
// tb_mcu_rst_sequencer: directed scoreboard bench for the staged reset sequencer
module tb_mcu_rst_sequencer;
  localparam int H = 16;
  localparam int G = 4;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [1:0] cpu_pad_soft_rst = 2'b00;
  logic wdt_rst_req = 1'b0;
  logic had_dbg_rst_req = 1'b0;
  logic rst_cause_clr = 1'b0;
  logic periph_rst_b, pad_had_rst_b, pad_cpu_rst_b, seq_busy;
  logic [4:0] rst_cause;
  logic [4:0] cause_exp;
  int n_chk = 0;
  int n_fail = 0;
  string tag_q[$];
  logic [8:0] exp_q[$];
  always #5 sys_clk = ~sys_clk;
  mcu_rst_sequencer #(.HOLD_CYCLES(H), .STAGE_GAP(G)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .cpu_pad_soft_rst(cpu_pad_soft_rst),
    .wdt_rst_req(wdt_rst_req),
    .had_dbg_rst_req(had_dbg_rst_req),
    .rst_cause_clr(rst_cause_clr),
    .periph_rst_b(periph_rst_b),
    .pad_had_rst_b(pad_had_rst_b),
    .pad_cpu_rst_b(pad_cpu_rst_b),
    .rst_cause(rst_cause),
    .seq_busy(seq_busy)
  );
  task automatic expect_next(input string tag, input logic p, input logic h, input logic c, input logic b);
    string t;
    logic [8:0] e, obs;
    tag_q.push_back(tag);
    exp_q.push_back({p, h, c, b, cause_exp});
    @(posedge sys_clk);
    #1;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    obs = {periph_rst_b, pad_had_rst_b, pad_cpu_rst_b, seq_busy, rst_cause};
    n_chk++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed {periph,had,cpu,busy,cause}=%b required %b", t, obs, e);
    end
  endtask
  task automatic sys_seq(input string tag, input int rel, input int d0, input int d1);
    for (int d = d0; d <= d1; d++)
      expect_next(tag, d >= rel, d >= rel + G, d >= rel + 2 * G, d < rel + 2 * G);
  endtask
  task automatic core_seq(input string tag, input int d0, input int d1);
    for (int d = d0; d <= d1; d++)
      expect_next(tag, 1'b1, 1'b1, d >= H, d < H);
  endtask
  task automatic clear_cause();
    rst_cause_clr = 1'b1;
    cause_exp = 5'b00000;
    expect_next("cause_clr", 1'b1, 1'b1, 1'b1, 1'b0);
    rst_cause_clr = 1'b0;
  endtask
  initial begin
    cause_exp = 5'b10000;
    repeat (3) expect_next("por_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    sys_rst = 1'b0;
    sys_seq("por_release", H, 0, H + 2 * G + 1);
    cpu_pad_soft_rst = 2'b01;
    cause_exp = 5'b10001;
    core_seq("cpu_soft", 0, 0);
    cpu_pad_soft_rst = 2'b00;
    core_seq("cpu_soft", 1, H + 1);
    clear_cause();
    wdt_rst_req = 1'b1;
    cause_exp = 5'b00100;
    sys_seq("wdt_held", 40, 0, 39);
    wdt_rst_req = 1'b0;
    sys_seq("wdt_held", 40, 40, 40 + 2 * G + 1);
    clear_cause();
    wdt_rst_req = 1'b1;
    cpu_pad_soft_rst = 2'b01;
    cause_exp = 5'b00101;
    sys_seq("sys_and_core", H, 0, 0);
    wdt_rst_req = 1'b0;
    cpu_pad_soft_rst = 2'b00;
    sys_seq("sys_and_core", H, 1, H + 2 * G + 1);
    clear_cause();
    cpu_pad_soft_rst = 2'b10;
    cause_exp = 5'b00010;
    sys_seq("restart", H, 0, 0);
    cpu_pad_soft_rst = 2'b00;
    sys_seq("restart", H, 1, H + 1);
    cpu_pad_soft_rst = 2'b10;
    sys_seq("restart", H, 0, 0);
    cpu_pad_soft_rst = 2'b00;
    sys_seq("restart", H, 1, H + 2 * G + 1);
    had_dbg_rst_req = 1'b1;
    rst_cause_clr = 1'b1;
    cause_exp = 5'b01000;
    core_seq("clr_vs_dbg", 0, 0);
    had_dbg_rst_req = 1'b0;
    rst_cause_clr = 1'b0;
    core_seq("clr_vs_dbg", 1, H + 1);
    wdt_rst_req = 1'b1;
    cause_exp = 5'b01100;
    sys_seq("abort", H, 0, 0);
    wdt_rst_req = 1'b0;
    sys_seq("abort", H, 1, 2);
    cpu_pad_soft_rst = 2'b01;
    cause_exp = 5'b01101;
    sys_seq("core_in_hold", H, 3, 3);
    cpu_pad_soft_rst = 2'b00;
    sys_seq("core_in_hold", H, 4, H + 1);
    sys_rst = 1'b1;
    cause_exp = 5'b10000;
    expect_next("abort_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    sys_rst = 1'b0;
    sys_seq("abort_release", H, 0, H + 2 * G + 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
